// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase accumulator NCO feeding the pipelined CORDIC stage.
// Emits one DATA_WIDTH-bit phase word per enabled clock (2^DATA_WIDTH == 2*pi).
// It supports fixed-frequency operation, phase-continuous retune and a linear
// frequency sweep (chirp). All state advances only while the shared CORDIC
// stall `ena` is high.
//
// The datapath is organised around "current" operands. On an accept edge these
// are the newly offered config values; otherwise they are the registered ones.
// The accept edge is therefore an ordinary sample edge that already runs on the
// new fcw/poff/step/len. This gives one-clock accept latency, bubble-free
// retune, and a sweep whose first sample is produced on the accept edge itself.
module nco_phase_gen #(
    parameter int ACC_WIDTH  = 24,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  stop,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_mode,
    input  logic [ACC_WIDTH-1:0]  cfg_fcw,
    input  logic [ACC_WIDTH-1:0]  cfg_step,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] cfg_poff,
    output logic [DATA_WIDTH-1:0] phase_out,
    output logic                  phase_valid,
    output logic                  sweep_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t                  state_q, state_d;

    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    fcw_q;
    logic [ACC_WIDTH-1:0]    step_q;
    logic [DATA_WIDTH-1:0]   poff_q;
    logic [LEN_WIDTH-1:0]    cnt_q;

    // Per-cycle control decode
    logic                    accept;
    logic                    active;
    logic                    sweeping;
    logic                    last;

    // Operands used by this edge (new config on accept, registers otherwise)
    logic [ACC_WIDTH-1:0]    acc_cur;
    logic [ACC_WIDTH-1:0]    fcw_cur;
    logic [ACC_WIDTH-1:0]    step_cur;
    logic [DATA_WIDTH-1:0]   poff_cur;
    logic [LEN_WIDTH-1:0]    cnt_cur;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic [DATA_WIDTH-1:0]   phase_top;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake and operand selection
    always_comb begin
        cfg_ready = ena & ~stop & (state_q != SWEEP);
        accept    = cfg_valid & cfg_ready;
        active    = ena & ~stop & (accept | (state_q != IDLE));
        sweeping  = accept ? cfg_mode : (state_q == SWEEP);

        // A zero-length sweep still produces one sample
        len_eff   = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
        cnt_cur   = accept ? len_eff  : cnt_q;
        fcw_cur   = accept ? cfg_fcw  : fcw_q;
        step_cur  = accept ? cfg_step : step_q;
        poff_cur  = accept ? cfg_poff : poff_q;
        // Starting from IDLE begins at phase zero; a RUN retune keeps the phase
        acc_cur   = (accept && (state_q == IDLE)) ? '0 : acc_q;
        phase_top = acc_cur[ACC_WIDTH-1 -: DATA_WIDTH];

        last      = active & sweeping & (cnt_cur == LEN_WIDTH'(1));

        state_d = state_q;
        if (ena) begin
            if (stop) begin
                state_d = IDLE;
            end else if (last) begin
                state_d = RUN;
            end else if (accept) begin
                state_d = cfg_mode ? SWEEP : RUN;
            end
        end
    end

    // Accumulator, sweep engine and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            fcw_q       <= '0;
            step_q      <= '0;
            poff_q      <= '0;
            cnt_q       <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            // One-clock pulse; `last` is already qualified by ena
            sweep_done <= last;
            if (ena) begin
                if (stop) begin
                    // fcw/poff are kept so a later look at them stays meaningful
                    acc_q       <= '0;
                    phase_valid <= 1'b0;
                end else if (active) begin
                    phase_out   <= phase_top + poff_cur;
                    acc_q       <= acc_cur + fcw_cur;
                    phase_valid <= 1'b1;
                    step_q      <= step_cur;
                    poff_q      <= poff_cur;
                    if (sweeping) begin
                        fcw_q <= fcw_cur + step_cur;
                        cnt_q <= cnt_cur - LEN_WIDTH'(1);
                    end else begin
                        fcw_q <= fcw_cur;
                        cnt_q <= cnt_cur;
                    end
                end else begin
                    // IDLE: last phase word is held, marked not live
                    phase_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/nco_phase_gen.md
# nco_phase_gen

Phase generator that drives the pipelined CORDIC sin/cos stage: a phase accumulator with programmable frequency control word (FCW), phase offset and an optional linear frequency sweep (chirp). Each enabled cycle it emits one DATA_WIDTH-bit phase word, scaled so that 2^DATA_WIDTH equals 2π (8'h40 = π/2). It shares the CORDIC's global `ena` stall so both pipelines advance in lockstep.

## Interface
- ACC_WIDTH, 24: accumulator and FCW width; phase output is the top DATA_WIDTH bits.
- DATA_WIDTH, 8: output phase width (matches CORDIC phase input).
- LEN_WIDTH, 16: sweep length counter width.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global clock enable; all state holds when low.
- stop  in  1  synchronous return to IDLE (qualified by ena).
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready.
- cfg_mode  in  1  0 = fixed frequency, 1 = sweep.
- cfg_fcw  in  ACC_WIDTH  frequency control word (unsigned, modulo 2^ACC_WIDTH).
- cfg_step  in  ACC_WIDTH  per-sample FCW increment in sweep (two's complement).
- cfg_len  in  LEN_WIDTH  number of sweep samples.
- cfg_poff  in  DATA_WIDTH  phase offset added to output.
- phase_out  out  DATA_WIDTH  phase word to CORDIC.
- phase_valid  out  1  phase_out is a live sample.
- sweep_done  out  1  one-clock pulse marking the last sweep sample.

## Operation
- States: IDLE, RUN, SWEEP. Reset: state IDLE, acc 0, fcw/step/poff/cnt 0, phase_out 0, phase_valid 0, sweep_done 0.
- cfg_ready = ena & ~stop & (state == IDLE or RUN); combinational. 0 in SWEEP.
- Accept (cfg_valid & cfg_ready): load fcw, step, poff; cnt <= (cfg_len == 0) ? 1 : cfg_len; next state RUN if cfg_mode = 0, else SWEEP.
  - From IDLE: acc <= 0 (phase starts at poff).
  - From RUN: acc not reset (phase-continuous retune); new fcw/poff take effect on the same edge.
- Per ena cycle in RUN or SWEEP (no stop): phase_out <= acc[ACC_WIDTH-1 -: DATA_WIDTH] + poff (mod 2^DATA_WIDTH); acc <= acc + fcw (mod 2^ACC_WIDTH); phase_valid <= 1. On an accept edge, the output uses the pre-accept acc and the newly loaded poff.
- SWEEP additionally: fcw <= fcw + step (wraps mod 2^ACC_WIDTH); cnt <= cnt − 1; when cnt == 1: state <= RUN, sweep_done <= 1. RUN continues at the final fcw.
- IDLE: phase_out holds its last value, phase_valid <= 0.
- stop & ena: state <= IDLE, acc <= 0, phase_valid <= 0, fcw/poff retained; stop has priority over cfg_valid (cfg_ready forced 0).
- ena = 0: no register changes except sweep_done, which is cleared on every clock after the one in which it was set (it is high for exactly one clock).
- Asynchronous reset mid-sweep: immediate return to the reset values; no sweep_done is issued.

## Timing
- Accept-to-first-sample latency: 1 enabled clock (phase_out/phase_valid registered on the accept edge).
- Throughput: one phase word per ena cycle; no bubbles on RUN retune or SWEEP→RUN transition.
- sweep_done is asserted in the same cycle that phase_out shows the last (cnt == 1) sweep sample.
- Downstream CORDIC adds its own fixed latency; quadrant bits are phase_out[DATA_WIDTH-1:DATA_WIDTH-2].

## Test plan
- Reset, then fixed mode with fcw = 24'h040000 and poff = 8'h10 → phase_out = 10, 14, 18, 1C, … with phase_valid high from the first cycle after accept.
- Wrap check with fcw = 24'h400000 and poff = 0 → 00, 40, 80, C0, 00, 40 (continuous wrap, no glitch).
- Sweep with fcw = 24'h010000, step = 24'h010000, len = 3 → 00, 01, 03 (sweep_done high with 03), then RUN outputs 06, 0A, 0E (fcw = 24'h040000).
- ena toggled low for 3 cycles mid-RUN → phase_out, acc and phase_valid frozen; the sequence resumes exactly where it stopped; cfg_ready = 0 while ena = 0.
- Retune in RUN from fcw = 24'h040000 to 24'h080000 after output 08 → next outputs 0C, 14, 1C (phase-continuous); cfg_ready = 0 throughout a SWEEP.
- stop asserted together with cfg_valid mid-sweep → no accept, IDLE, phase_valid 0 next cycle, no sweep_done; async rst_n pulse mid-sweep → all outputs 0 immediately.
